alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
//  Issue-side controller for the 16-bit combinational ALU. Takes ALU instructions over a
//  valid/ready handshake and reads operands from an internal register file. Drives
//  a_in/b_in/alu_sel/c_in, then writes the ALU result into the register file and updates
//  the carry/zero flags. Sits between the instruction decoder and the ALU.
// PARAMETERS
//  DATA_W   16  operand/result width; must equal the ALU width
//  NREGS     8  register file depth
//  REG_AW    3  register address width, $clog2(NREGS)
// PORTS
//  clk           in   1       single clock
//  rst           in   1       synchronous, active-high reset
//  instr_valid   in   1       instruction offered
//  instr_ready   out  1       controller can accept; handshake when valid&&ready
//  instr_op      in   4       ALU opcode; 0..12 legal
//  instr_rd      in   REG_AW  destination register
//  instr_ra      in   REG_AW  operand A register
//  instr_rb      in   REG_AW  operand B register (unused when use_imm=1)
//  instr_use_imm in   1       B = instr_imm instead of regfile[rb]
//  instr_imm     in   DATA_W  immediate
//  instr_use_c   in   1       c_in = carry flag, else 0
//  alu_a         out  DATA_W  to ALU a_in
//  alu_b         out  DATA_W  to ALU b_in
//  alu_sel       out  4       to ALU alu_sel
//  alu_cin       out  1       to ALU c_in
//  alu_out       in   DATA_W  from ALU out
//  alu_cout      in   1       from ALU c_out
//  res_valid     out  1       1-cycle pulse: writeback done
//  res_data      out  DATA_W  value written (held until next res_valid)
//  flag_c        out  1       carry flag
//  flag_z        out  1       zero flag
//  err_illegal   out  1       1-cycle pulse: illegal opcode dropped
//  dbg_addr      in   REG_AW  debug read address
//  dbg_data      out  DATA_W  regfile[dbg_addr], combinational
// BEHAVIOUR
//  Reset values: all regs=0; flag_c=0; flag_z=0; res_valid=0; res_data=0; err_illegal=0.
//   State=IDLE after reset. A reset in any state abandons the in-flight op with no writeback.
//  FSM IDLE -> ISSUE -> IDLE. instr_ready = (state==IDLE). Throughput is 1 instr / 2 cycles.
//  IDLE: on handshake, latch op/rd/ra/rb/use_imm/imm/use_c and go to ISSUE.
//  ISSUE: alu_a=reg[ra]; alu_b = use_imm ? imm : reg[rb]; alu_sel=op;
//   alu_cin = use_c & flag_c. All four ALU outputs are 0 outside ISSUE.
//   At the end of ISSUE (same edge), for legal op:
//   - write reg[rd]<=alu_out; res_data<=alu_out; res_valid pulses in the next cycle.
//   - flag_z <= (alu_out==0).
//   - flag_c <= alu_cout only for op 0 (ADD) and op 1 (SUB). For all other ops, flag_c
//     holds and alu_cout is ignored, because the ALU does not drive c_out for them.
//  Illegal op (13..15): no reg/flag/res_data update; err_illegal pulses in the next cycle.
//  Latency: handshake edge N -> ISSUE in cycle N+1 -> result in reg/flags and
//   res_valid=1 in cycle N+2. The earliest next instr issues in N+3 and sees the new value
//   (no hazard logic needed).
//  rd==ra or rd==rb: the operand is read before the write (old value used).
//  ADD/SUB arithmetic: 17-bit {c,out}; SUB computes a-b+cin (no borrow inversion).
//  Shifts: alu_b is passed as the full 16 bits; amounts >=16 are the ALU's concern.
//  dbg_data reads the committed regfile; a same-cycle write is not bypassed.
// STRUCTURE
//  alu_pkg: typedef enum logic[3:0] alu_op_e {ADD,SUB,OR,AND,XOR,NOR,NAND,SHL,SHR,
//   ASHL,ASHR,ASHL2,NOT}; localparam ALU_OP_MAX=4'd12; typedef enum {IDLE,ISSUE} exec_st_e.
//  One sub-module: alu_regfile (NREGS x DATA_W; 3 async read ports ra/rb/dbg,
//   1 sync write port). The ALU itself is instantiated alongside, not inside.
// TESTING (bench instantiates alu_exec_ctrl + alu)
//  1 Reset: all regs 0, flags 0, instr_ready=1. Then ADD r1=r0+imm 0x0005 ->
//    res_valid at N+2, res_data=0x0005, flag_z=0, flag_c=0.
//  2 Carry chain: r1=0xFFFF; ADD r2=r1+imm 1 -> r2=0x0000, flag_c=1, flag_z=1.
//    Then ADD use_c r3=r0+imm 0 -> r3=0x0001.
//  3 Flag hold: with flag_c=1, XOR r4=r1^r1 -> r4=0, flag_z=1, flag_c stays 1.
//  4 Illegal: op=4'hE -> err_illegal pulse, no res_valid, regs/flags unchanged.
//  5 Back-to-back: valid held high for 3 instrs -> ready toggles 1,0; 3 handshakes in
//    6 cycles; an RAW chain (r5=r5+1 x3) ends at r5=3.
//  6 Reset mid-op: rst asserted during ISSUE of ADD r6 -> r6=0, res_valid never
//    pulses, instr_ready=1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcode encoding, FSM states and
// small opcode-classification helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    OR    = 4'd2,
    AND   = 4'd3,
    XOR   = 4'd4,
    NOR   = 4'd5,
    NAND  = 4'd6,
    SHL   = 4'd7,
    SHR   = 4'd8,
    ASHL  = 4'd9,
    ASHR  = 4'd10,
    ASHL2 = 4'd11,
    NOT   = 4'd12
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd12;

  typedef enum logic {IDLE, ISSUE} exec_st_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= ALU_OP_MAX;
  endfunction

  // Only ADD and SUB drive a meaningful c_out from the ALU.
  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x DATA_W, three asynchronous read ports (A, B, debug)
// and one synchronous write port; cleared on reset.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads return committed contents; a write in the same cycle is not forwarded.
  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue-side controller for the combinational ALU: accepts one instruction per
// two cycles, drives the ALU for one ISSUE cycle, then commits result and flags.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_c,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              err_illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  exec_st_e          state;
  logic              vld_p0;
  logic [3:0]        op_p0;
  logic [REG_AW-1:0] rd_p0;
  logic [REG_AW-1:0] ra_p0;
  logic [REG_AW-1:0] rb_p0;
  logic              use_imm_p0;
  logic              use_c_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              wr_en;

  assign instr_ready = (state == IDLE);
  assign vld_p0      = (state == ISSUE);
  assign wr_en       = vld_p0 && op_legal(op_p0);

  // Stage p0: instruction fields captured at the handshake, held through ISSUE
  always_ff @(posedge clk) begin
    if (instr_ready && instr_valid) begin
      op_p0      <= instr_op;
      rd_p0      <= instr_rd;
      ra_p0      <= instr_ra;
      rb_p0      <= instr_rb;
      use_imm_p0 <= instr_use_imm;
      use_c_p0   <= instr_use_c;
      imm_p0     <= instr_imm;
    end
  end

  // ALU drive during ISSUE; zeroed otherwise so the ALU sees a quiet bus
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    if (vld_p0) begin
      alu_a   = ra_data;
      alu_b   = use_imm_p0 ? imm_p0 : rb_data;
      alu_sel = op_p0;
      alu_cin = use_c_p0 & flag_c;
    end
  end

  // Stage p1: writeback and flag update at the end of ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      res_valid   <= 1'b0;
      res_data    <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      res_valid   <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) state <= ISSUE;
        end
        ISSUE: begin
          state <= IDLE;
          if (op_legal(op_p0)) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            flag_z    <= (alu_out == '0);
            if (op_sets_carry(op_p0)) flag_c <= alu_cout;
          end else begin
            err_illegal <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .waddr    (rd_p0),
    .wdata    (alu_out),
    .ra_addr  (ra_p0),
    .ra_data  (ra_data),
    .rb_addr  (rb_p0),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural 16-bit ALU beside the controller and an
// architectural model (register array plus flags) predicting every commit.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic        instr_use_imm;
  logic [15:0] instr_imm;
  logic        instr_use_c;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_cin, alu_cout;
  logic        res_valid;
  logic [15:0] res_data;
  logic        flag_c, flag_z, err_illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        junk_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_regs [8];
  logic        m_c, m_z;
  logic [15:0] m_res;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm), .instr_use_c(instr_use_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_data(res_data), .flag_c(flag_c), .flag_z(flag_z),
    .err_illegal(err_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: returns {carry, result}
  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] s;
    s = '0;
    case (op)
      4'd0:  s = {1'b0, a} + {1'b0, b} + 17'(cin);
      4'd1:  s = {1'b0, a} - {1'b0, b} + 17'(cin);
      4'd2:  s[15:0] = a | b;
      4'd3:  s[15:0] = a & b;
      4'd4:  s[15:0] = a ^ b;
      4'd5:  s[15:0] = ~(a | b);
      4'd6:  s[15:0] = ~(a & b);
      4'd7:  s[15:0] = a << b;
      4'd8:  s[15:0] = a >> b;
      4'd9:  s[15:0] = a <<< b;
      4'd10: s[15:0] = 16'($signed(a) >>> b);
      4'd11: s[15:0] = a << 2;
      4'd12: s[15:0] = ~a;
      default: s = '0;
    endcase
    return s;
  endfunction

  // Non-arithmetic ops leave c_out as junk, which the controller must ignore
  always_comb begin
    {alu_cout, alu_out} = alu_f(alu_sel, alu_a, alu_b, alu_cin);
    if (alu_sel > 4'd1) alu_cout = junk_c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_c = 1'b0; m_z = 1'b0; m_res = '0;
  endtask

  // Runs one instruction through handshake, ISSUE and writeback; starts and ends near negedge
  task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input logic use_imm, input logic [15:0] imm,
                          input logic use_c);
    logic [15:0] a, b, wv;
    logic        cin, legal;
    logic [16:0] r;
    int          waited;
    a     = m_regs[ra];
    b     = use_imm ? imm : m_regs[rb];
    cin   = use_c & m_c;
    legal = (op <= 4'd12);
    junk_c = ~m_c;
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_use_imm = use_imm; instr_imm = imm; instr_use_c = use_c;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 10) begin
      check("handshake_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("issue_ready", instr_ready, 1'b0);
    check("issue_res_valid", res_valid, 1'b0);
    check("issue_alu_a", alu_a, a);
    check("issue_alu_b", alu_b, b);
    check("issue_alu_sel", alu_sel, op);
    check("issue_alu_cin", alu_cin, cin);
    if (legal) begin
      r = alu_f(op, a, b, cin);
      wv = r[15:0];
      m_regs[rd] = wv;
      m_res = wv;
      m_z = (wv == 16'd0);
      if (op <= 4'd1) m_c = r[16];
    end
    @(posedge clk);
    #1;
    check("wb_res_valid", res_valid, legal);
    check("wb_err_illegal", err_illegal, !legal);
    check("wb_res_data", res_data, m_res);
    check("wb_flag_c", flag_c, m_c);
    check("wb_flag_z", flag_z, m_z);
    check("wb_ready", instr_ready, 1'b1);
    dbg_addr = rd;
    #1;
    check("wb_reg_rd", dbg_data, m_regs[rd]);
    @(negedge clk);
  endtask

  int hs_count;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_ra = '0;
    instr_rb = '0; instr_use_imm = 1'b0; instr_imm = '0; instr_use_c = 1'b0;
    dbg_addr = '0; junk_c = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_reg", dbg_data, 16'd0);
    end
    check("rst_ready", instr_ready, 1'b1);
    check("rst_flag_c", flag_c, 1'b0);
    check("rst_flag_z", flag_z, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'd0);
    check("rst_err", err_illegal, 1'b0);
    check("idle_alu_a", alu_a, 16'd0);
    check("idle_alu_sel", alu_sel, 4'd0);
    @(negedge clk);

    do_instr(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0);

    // Carry chain
    do_instr(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0);
    do_instr(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0);
    check("carry_set", flag_c, 1'b1);
    do_instr(4'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b1);
    dbg_addr = 3'd3; #1;
    check("carry_in_r3", dbg_data, 16'h0001);
    @(negedge clk);

    // Flag hold on a logic op
    do_instr(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b0);
    do_instr(4'd4, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b0);
    check("xor_hold_c", flag_c, 1'b1);
    check("xor_z", flag_z, 1'b1);

    // Illegal opcode
    do_instr(4'hE, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0);
    dbg_addr = 3'd1; #1;
    check("illegal_r1_kept", dbg_data, 16'hFFFF);
    @(negedge clk);

    // Back-to-back: valid held high for a RAW chain r5 = r5 + 1
    instr_op = 4'd0; instr_rd = 3'd5; instr_ra = 3'd5; instr_rb = 3'd0;
    instr_use_imm = 1'b1; instr_imm = 16'h0001; instr_use_c = 1'b0;
    instr_valid = 1'b1;
    hs_count = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      check("b2b_ready", instr_ready, (cyc % 2 == 0));
      if (instr_ready) hs_count++;
      @(posedge clk);
      #1;
      if (hs_count == 3) instr_valid = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_handshakes", hs_count, 3);
    dbg_addr = 3'd5; #1;
    check("b2b_r5", dbg_data, 16'd3);
    m_regs[5] = 16'd3; m_res = 16'd3; m_c = 1'b0; m_z = 1'b0;
    check("b2b_res_data", res_data, m_res);
    check("b2b_flag_c", flag_c, m_c);
    @(negedge clk);

    // Reset during ISSUE abandons the op
    instr_op = 4'd0; instr_rd = 3'd6; instr_ra = 3'd0; instr_rb = 3'd0;
    instr_use_imm = 1'b1; instr_imm = 16'h0007; instr_use_c = 1'b0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("midrst_in_issue", instr_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_ready", instr_ready, 1'b1);
    dbg_addr = 3'd6; #1;
    check("midrst_r6", dbg_data, 16'd0);
    @(posedge clk);
    #1;
    check("midrst_res_valid2", res_valid, 1'b0);
    check("midrst_err", err_illegal, 1'b0);
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic [3:0] rop;
      rop = (($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) rop = 4'($urandom_range(0, 1));
      do_instr(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("final_reg", dbg_data, m_regs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
